// File: rtl/segre_param_store_buffer_if.sv
// Store-buffer memop type package and the request/forward/drain interface.
// Build option SEGRE_SB_COALESCE_EN affects the buffer only, not this bundle.
package segre_sb_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memop_data_type_e;
endpackage

interface segre_param_store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
);
    logic                           store_req_i;
    logic [ADDR_W-1:0]              store_addr_i;
    logic [31:0]                    store_data_i;
    segre_sb_pkg::memop_data_type_e store_type_i;
    logic                           store_ack_o;
    logic                           misaligned_o;

    logic                           load_req_i;
    logic [ADDR_W-1:0]              load_addr_i;
    segre_sb_pkg::memop_data_type_e load_type_i;
    logic                           load_hit_o;
    logic                           load_trouble_o;
    logic [31:0]                    load_data_o;

    logic                           drain_valid_o;
    logic                           drain_ready_i;
    logic [ADDR_W-1:0]              drain_addr_o;
    logic [3:0]                     drain_mask_o;
    logic [31:0]                    drain_data_o;

    logic                           full_o;
    logic                           empty_o;
    logic [$clog2(DEPTH+1)-1:0]     count_o;

    modport master (
        output store_req_i, store_addr_i, store_data_i, store_type_i,
        input  store_ack_o, misaligned_o,
        output load_req_i, load_addr_i, load_type_i,
        input  load_hit_o, load_trouble_o, load_data_o,
        input  drain_valid_o, drain_addr_o, drain_mask_o, drain_data_o,
        output drain_ready_i,
        input  full_o, empty_o, count_o
    );

    modport slave (
        input  store_req_i, store_addr_i, store_data_i, store_type_i,
        output store_ack_o, misaligned_o,
        input  load_req_i, load_addr_i, load_type_i,
        output load_hit_o, load_trouble_o, load_data_o,
        output drain_valid_o, drain_addr_o, drain_mask_o, drain_data_o,
        input  drain_ready_i,
        output full_o, empty_o, count_o
    );
endinterface

// File: rtl/segre_param_store_buffer.sv
// Circular store buffer with youngest-match load forwarding and in-order drain.
// Define SEGRE_SB_COALESCE_EN to merge stores into the youngest entry on a word match.
module segre_param_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input logic                      clk_i,
    input logic                      rst_i,
    segre_param_store_buffer_if.slave sb
);
    import segre_sb_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int WA = ADDR_W - 2;

    logic [WA-1:0] waddr_q [DEPTH];
    logic [3:0]    mask_q  [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [3:0]    st_mask;
    logic [31:0]   st_data, st_bmask;
    logic          st_mis, empty, full, pop, push, ack, coal;

    always_comb begin
        st_mask = 4'b0000;
        st_data = sb.store_data_i;
        st_mis  = 1'b0;
        case (sb.store_type_i)
            BYTE: begin
                st_mask = 4'b0001 << sb.store_addr_i[1:0];
                st_data = {4{sb.store_data_i[7:0]}};
            end
            HALF: begin
                st_mask = sb.store_addr_i[1] ? 4'b1100 : 4'b0011;
                st_data = {2{sb.store_data_i[15:0]}};
                st_mis  = sb.store_addr_i[0];
            end
            WORD: begin
                st_mask = 4'b1111;
                st_mis  = (sb.store_addr_i[1:0] != 2'b00);
            end
            default: st_mask = 4'b0000;
        endcase
        st_bmask = {{8{st_mask[3]}}, {8{st_mask[2]}}, {8{st_mask[1]}}, {8{st_mask[0]}}};
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = !empty && sb.drain_ready_i;

`ifdef SEGRE_SB_COALESCE_EN
    logic [PW-1:0] tail_m1;
    assign tail_m1 = tail_q - PW'(1);
    // The youngest entry is only the head when count is 1, so that is the only popping case.
    assign coal    = !empty && (waddr_q[tail_m1] == sb.store_addr_i[ADDR_W-1:2])
                     && !(pop && (head_q == tail_m1));
`else
    assign coal    = 1'b0;
`endif

    assign ack     = sb.store_req_i && !st_mis && (!full || coal) && !rst_i;
    assign push    = ack && !coal;
    assign head_d  = head_q + PW'(pop);
    assign tail_d  = tail_q + PW'(push);
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                mask_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                waddr_q[tail_q] <= sb.store_addr_i[ADDR_W-1:2];
                mask_q[tail_q]  <= st_mask;
                data_q[tail_q]  <= st_data & st_bmask;
            end
`ifdef SEGRE_SB_COALESCE_EN
            else if (ack && coal) begin
                mask_q[tail_m1] <= mask_q[tail_m1] | st_mask;
                data_q[tail_m1] <= (data_q[tail_m1] & ~st_bmask) | (st_data & st_bmask);
            end
`endif
        end
    end

    logic [3:0]    ld_mask, sel_mask;
    logic [1:0]    ld_off;
    logic [31:0]   sel_data, shifted, ld_ext;
    logic [PW-1:0] idx;
    logic          found, active, covers;

    always_comb begin
        ld_mask = 4'b1111;
        ld_off  = 2'b00;
        case (sb.load_type_i)
            BYTE: begin
                ld_mask = 4'b0001 << sb.load_addr_i[1:0];
                ld_off  = sb.load_addr_i[1:0];
            end
            HALF: begin
                ld_mask = sb.load_addr_i[1] ? 4'b1100 : 4'b0011;
                ld_off  = {sb.load_addr_i[1], 1'b0};
            end
            default: ld_mask = 4'b1111;
        endcase
        found    = 1'b0;
        sel_mask = 4'b0000;
        sel_data = '0;
        idx      = '0;
        // Walk oldest to youngest so the last match left standing is the youngest.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (waddr_q[idx] == sb.load_addr_i[ADDR_W-1:2])
                && ((mask_q[idx] & ld_mask) != 4'b0000)) begin
                found    = 1'b1;
                sel_mask = mask_q[idx];
                sel_data = data_q[idx];
            end
        end
        shifted = sel_data >> {ld_off, 3'b000};
        case (sb.load_type_i)
            BYTE:    ld_ext = {24'b0, shifted[7:0]};
            HALF:    ld_ext = {16'b0, shifted[15:0]};
            default: ld_ext = shifted;
        endcase
        active = sb.load_req_i && !rst_i && found;
        covers = ((sel_mask & ld_mask) == ld_mask);
    end

    assign sb.store_ack_o    = ack;
    assign sb.misaligned_o   = sb.store_req_i && st_mis;
    assign sb.load_hit_o     = active && covers;
    assign sb.load_trouble_o = active && !covers;
    assign sb.load_data_o    = (active && covers) ? ld_ext : 32'b0;
    assign sb.drain_valid_o  = !empty;
    assign sb.drain_addr_o   = {waddr_q[head_q], 2'b00};
    assign sb.drain_mask_o   = mask_q[head_q];
    assign sb.drain_data_o   = data_q[head_q];
    assign sb.full_o         = full;
    assign sb.empty_o        = empty;
    assign sb.count_o        = count_q;
endmodule
